// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_e;

  localparam int LIT_W = 2;

  // Clamp the decoded literal-word count to the largest skip the core supports.
  function automatic logic [LIT_W-1:0] sat_literal(input logic [LIT_W-1:0] words,
                                                   input int lit_max);
    if (int'(words) > lit_max) return LIT_W'(lit_max);
    return words;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-side control in, fetch address and status out of the PC sequencer.
interface pc_sequencer_if #(parameter int PC_W = 16);
  import pc_seq_pkg::*;

  // No valid/ready pair here: the decode controls are sampled every clock and
  // fetch_valid qualifies pc_out in the same cycle; stall is the only backpressure.
  logic             stall;
  logic             branch;
  logic             cond_pass;
  logic [PC_W-1:0]  br_offset;
  logic             is_call;
  logic             is_return;
  logic [LIT_W-1:0] literal_words;
  logic [PC_W-1:0]  pc_out;
  logic             fetch_valid;
  logic             flushing;
  logic             ras_overflow;
  logic             ras_underflow;
  pc_state_e        state_dbg;

  modport master (
    output stall, branch, cond_pass, br_offset, is_call, is_return, literal_words,
    input  pc_out, fetch_valid, flushing, ras_overflow, ras_underflow, state_dbg
  );

  modport slave (
    input  stall, branch, cond_pass, br_offset, is_call, is_return, literal_words,
    output pc_out, fetch_valid, flushing, ras_overflow, ras_underflow, state_dbg
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(RAS_DEPTH));
  assign top    = mem[sp - PTR_W'(1)];
  assign do_pop = pop && !push && !empty;

  // sp always points at the next free slot and wraps, so overwriting the
  // oldest entry on overflow falls out of the pointer arithmetic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full;
      underflow <= pop && !push && empty;
      if (push) begin
        sp <= sp + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (do_pop) begin
        sp    <= sp - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC sequencer: branch/call/return redirects, literal skip, flush bubbles.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_VEC    = '0,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              LITERAL_MAX  = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  pc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [PC_W-1:0]  ras_top;
  logic             ras_empty, ras_full;
  logic             br_taken, ret_req, ret_taken, redirect, push, pop;
  logic [LIT_W-1:0] skip;

  always_comb begin
    br_taken  = (state == RUN) && bus.branch && bus.cond_pass;
    ret_req   = (state == RUN) && bus.is_return && !bus.is_call && bus.cond_pass && !br_taken;
    ret_taken = ret_req && !ras_empty;
    redirect  = br_taken || ret_taken;
    push      = br_taken && bus.is_call;
    pop       = ret_req;
    skip      = bus.cond_pass ? sat_literal(bus.literal_words, LITERAL_MAX) : '0;

    pc_nxt    = pc_q;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        // The -1 on branch targets undoes the prefetch already reflected in pc_q.
        if (br_taken)        pc_nxt = pc_q + bus.br_offset - PC_W'(1);
        else if (ret_taken)  pc_nxt = ras_top;
        else if (!bus.stall) pc_nxt = pc_q + PC_W'(1) + PC_W'(skip);
        if (redirect && (FLUSH_CYCLES > 0)) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      pc_q  <= RESET_VEC;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc_q  <= pc_nxt;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.fetch_valid = (state == RUN);
  assign bus.flushing    = (state == FLUSH);
  assign bus.state_dbg   = state;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + PC_W'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (bus.ras_overflow),
    .underflow (bus.ras_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomised checks of pc_sequencer with an expected-output queue.
module tb_pc_sequencer;

  localparam int PC_W  = 16;
  localparam int EXP_W = PC_W + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W         (PC_W),
    .RESET_VEC    (16'h0000),
    .FLUSH_CYCLES (1),
    .LITERAL_MAX  (2),
    .RAS_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [EXP_W-1:0] exp_q[$];
  logic [PC_W-1:0]  cur_pc = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input logic rst, input logic st, input logic br, input logic cp,
                      input logic call, input logic ret, input logic [1:0] lw,
                      input logic [PC_W-1:0] ofs, input logic [PC_W-1:0] e_pc,
                      input logic e_v, input logic e_f, input logic e_o, input logic e_u);
    logic [EXP_W-1:0] e;
    reset             = rst;
    bus.stall         = st;
    bus.branch        = br;
    bus.cond_pass     = cp;
    bus.is_call       = call;
    bus.is_return     = ret;
    bus.literal_words = lw;
    bus.br_offset     = ofs;
    exp_q.push_back({e_pc, e_v, e_f, e_o, e_u});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("pc_out", 32'(bus.pc_out), 32'(e[EXP_W-1:4]));
      check_eq("fetch_valid", 32'(bus.fetch_valid), 32'(e[3]));
      check_eq("flushing", 32'(bus.flushing), 32'(e[2]));
      check_eq("ras_overflow", 32'(bus.ras_overflow), 32'(e[1]));
      check_eq("ras_underflow", 32'(bus.ras_underflow), 32'(e[0]));
    end
    cur_pc = e_pc;
  endtask

  task automatic seq(input logic [1:0] lw, input logic cp, input logic [PC_W-1:0] e_pc);
    step(0, 0, 0, cp, 0, 0, lw, 16'h0000, e_pc, 1, 0, 0, 0);
  endtask

  // Junk on stall/branch/return during the bubble must be ignored.
  task automatic flush_step();
    step(0, 1, 1, 1, 0, 1, 2'd3, 16'h0100, cur_pc, 1, 0, 0, 0);
  endtask

  task automatic goto_pc(input logic [PC_W-1:0] addr);
    step(0, 0, 1, 1, 0, 0, 2'd0, addr - cur_pc + 16'd1, addr, 0, 1, 0, 0);
    flush_step();
  endtask

  task automatic call_step(input logic [PC_W-1:0] ofs, input logic [PC_W-1:0] e_pc, input logic e_o);
    step(0, 0, 1, 1, 1, 0, 2'd0, ofs, e_pc, 0, 1, e_o, 0);
  endtask

  task automatic ret_step(input logic [PC_W-1:0] e_pc);
    step(0, 0, 0, 1, 0, 1, 2'd0, 16'h0000, e_pc, 0, 1, 0, 0);
  endtask

  initial begin
    logic [PC_W-1:0] e;
    logic [1:0]      lw;
    logic            cp, st;

    // Reset and free-running fetch
    step(1, 0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    seq(2'd0, 1, 16'h0001);
    seq(2'd0, 1, 16'h0002);
    seq(2'd0, 1, 16'h0003);

    // Plain branch with one bubble
    goto_pc(16'h0010);
    step(0, 0, 1, 1, 0, 0, 2'd0, 16'h0005, 16'h0014, 0, 1, 0, 0);
    flush_step();
    seq(2'd0, 1, 16'h0015);

    // Call, stall, return
    goto_pc(16'h0020);
    call_step(16'h0010, 16'h002F, 0);
    flush_step();
    seq(2'd0, 1, 16'h0030);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 2'd0, 16'h0000, 16'h0030, 1, 0, 0, 0);
    ret_step(16'h0021);
    flush_step();

    // Literal skip, clamped and suppressed
    goto_pc(16'h0008);
    seq(2'd3, 1, 16'h000B);
    goto_pc(16'h0008);
    seq(2'd3, 0, 16'h0009);

    // RAS now empty: return falls through with an underflow pulse
    step(0, 0, 0, 1, 0, 1, 2'd0, 16'h0000, 16'h000A, 1, 0, 0, 1);

    // Five calls into a 4-deep RAS, then five returns
    call_step(16'h0011, 16'h001A, 0); flush_step();
    call_step(16'h0011, 16'h002A, 0); flush_step();
    call_step(16'h0011, 16'h003A, 0); flush_step();
    call_step(16'h0011, 16'h004A, 0); flush_step();
    call_step(16'h0011, 16'h005A, 1); flush_step();
    ret_step(16'h004B); flush_step();
    ret_step(16'h003B); flush_step();
    ret_step(16'h002B); flush_step();
    ret_step(16'h001B); flush_step();
    step(0, 0, 0, 1, 0, 1, 2'd0, 16'h0000, 16'h001C, 1, 0, 0, 1);
    seq(2'd0, 1, 16'h001D);

    // Branch overrides stall
    step(0, 1, 1, 1, 0, 0, 2'd0, 16'h0005, 16'h0021, 0, 1, 0, 0);
    flush_step();

    // Wrap from all-ones
    goto_pc(16'hFFFF);
    seq(2'd0, 1, 16'h0000);

    // Reset in the middle of a flush clears the RAS
    call_step(16'h0010, 16'h000F, 0);
    step(1, 1, 1, 1, 0, 1, 2'd0, 16'h0040, 16'h0000, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 2'd0, 16'h0000, 16'h0001, 1, 0, 0, 1);

    // is_call with is_return but no branch: return ignored, plain advance
    step(0, 0, 0, 1, 1, 1, 2'd0, 16'h0000, 16'h0002, 1, 0, 0, 0);

    // Random sequential traffic with literals and stalls
    for (int i = 0; i < 24; i++) begin
      lw = 2'($urandom_range(0, 3));
      cp = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      if (st)      e = cur_pc;
      else if (cp) e = cur_pc + 16'd1 + ((lw > 2'd2) ? 16'd2 : 16'(lw));
      else         e = cur_pc + 16'd1;
      step(0, st, 0, cp, 0, 0, lw, 16'h0000, e, 1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter sequencer for the fetch stage; the successor to the current combinational PC update logic.
- Parametrised in PC width and in the number of flush cycles after a redirect.
- Adds a return-address stack (RAS) for call/return, and skips a configurable number of PC-relative literal words.
- Sits between decode/condition evaluation and the instruction memory address port.

Parameters:
- PC_W, 16, width of the PC and of all address/offset arithmetic.
- RESET_VEC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubble cycles after any redirect (0 allowed).
- LITERAL_MAX, 2, maximum extra words skipped for inline literals.
- RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold PC (pipeline stall)
- branch  in  1  decoded branch instruction in decode
- cond_pass  in  1  condition code of the decoded instruction is satisfied
- br_offset  in  PC_W  signed word offset of the branch
- is_call  in  1  branch is branch-with-link (push return address)
- is_return  in  1  instruction is a return (pop RAS)
- literal_words  in  2  extra literal words following the instruction
- pc_out  out  PC_W  current fetch address (registered)
- fetch_valid  out  1  pc_out is a valid fetch this cycle
- flushing  out  1  sequencer is in FLUSH state
- ras_overflow  out  1  one-cycle pulse: push while RAS full
- ras_underflow  out  1  one-cycle pulse: pop while RAS empty

Behaviour:
- All outputs are registered.
- Reset values: pc_out=RESET_VEC, fetch_valid=1, flushing=0, RAS empty, both pulses 0, state RUN, flush counter 0.
- Reset has priority over every other input.
- All PC arithmetic is modulo 2^PC_W; wrap from all-ones to 0 is legal and silent.
- States: RUN and FLUSH. FLUSH is unreachable when FLUSH_CYCLES=0.
- Priority in RUN: redirect > stall > sequential.
- Redirect when branch && cond_pass:
  - Target is pc_out + br_offset - 1; the -1 compensates for prefetch.
  - If is_call is also set, pc_out + 1 is pushed onto the RAS.
- Redirect when is_return && cond_pass && RAS non-empty:
  - Target is the RAS top; the top entry is popped.
- Return with an empty RAS:
  - No redirect; sequential advance applies.
  - ras_underflow pulses for one cycle.
- Both is_call and is_return set: is_return is ignored.
- On any redirect:
  - pc_out is loaded with the target on the next edge.
  - If FLUSH_CYCLES>0, the next state is FLUSH with the counter set to FLUSH_CYCLES.
  - A redirect overrides stall.
- FLUSH state:
  - pc_out holds.
  - fetch_valid=0 and flushing=1.
  - The counter decrements each cycle.
  - The state returns to RUN when the counter reaches 1 → 0.
  - stall, branch and is_return are ignored.
  - Net effect: exactly FLUSH_CYCLES bubble cycles.
- Stall in RUN: pc_out holds and fetch_valid stays 1.
- Sequential advance in RUN:
  - pc_out += 1 + skip, where skip = min(literal_words, LITERAL_MAX) if cond_pass, else 0.
  - Literal words are skipped only for executed instructions.
- RAS behaviour:
  - Circular buffer.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and pulses ras_overflow.
  - A pop after an overflow returns the most recent entries, in LIFO order.
- Reset mid-FLUSH returns to RUN at RESET_VEC on the next edge and clears the RAS.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum (RUN, FLUSH);
  - localparam for the literal-field width (2);
  - helper function sat_literal() for clamping to LITERAL_MAX.
- One sub-module, ras_stack: parametrised (PC_W, RAS_DEPTH) circular LIFO.
  - Ports: push, pop, push_data, top, empty, full, overflow, underflow.
  - Same clock and reset.
- The top level holds the FSM, the flush counter and the next-PC mux.

Test Plan:
- Reset then 3 free-running cycles with literal_words=0 → pc_out 0,1,2,3; fetch_valid=1 throughout.
- At pc_out=0x0010, branch=1, cond_pass=1, br_offset=0x0005, FLUSH_CYCLES=1 → next pc_out=0x0014; fetch_valid=0 for exactly 1 cycle; then pc_out=0x0015.
- At pc_out=0x0020, call with br_offset=0x0010 → pc_out=0x002F and RAS top=0x0021. Later, a return with cond_pass=1 → pc_out=0x0021 and the RAS is empty.
- At pc_out=0x0008, literal_words=3, cond_pass=1, LITERAL_MAX=2 → pc_out=0x000B. Repeat with cond_pass=0 → pc_out=0x0009.
- Five calls with RAS_DEPTH=4 → ras_overflow pulses on the 5th. Five returns → 4 correct addresses in LIFO order; ras_underflow pulses on the 5th with sequential advance.
- Edge cases:
  - stall held for 3 cycles at 0x0030 → pc_out stays 0x0030.
  - branch with stall → redirect wins.
  - pc_out=0xFFFF sequential → 0x0000.
  - reset asserted during FLUSH → pc_out=RESET_VEC, fetch_valid=1 on the next edge.
